ov5640_sccb_arb: RTL and testbench

Two-requester arbiter and sequencer in front of the single OV5640 SCCB write master. Requester 0 is the power-up register-table walker; requester 1 is runtime tuning logic (exposure, gain, test pattern). The block serialises write commands onto the master, enforces an idle gap between transactions and reports per-command completion and errors. It runs on the divided SCCB-domain clock and is held idle until the power sequencer raises sccb_begin.

---
 rtl/ov5640_pkg.sv | 18 +
 rtl/ov5640_sccb_arb.sv | 144 ++++++++++++++
 tb/tb_ov5640_sccb_arb.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ov5640_pkg.sv
// Shared types and constants for the OV5640 SCCB command path.
// Holds the arbiter FSM encoding, default bus widths and requester IDs.
package ov5640_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StGap   = 2'd3
  } sccb_arb_state_e;

  localparam int unsigned DefAddrW = 16;
  localparam int unsigned DefDataW = 8;

  localparam logic REQ_CFG = 1'b0;  // power-up register-table walker
  localparam logic REQ_RT  = 1'b1;  // runtime tuning logic

endpackage

// File: rtl/ov5640_sccb_arb.sv
// Two-requester round-robin arbiter/sequencer in front of the OV5640 SCCB write master.
// Optional WAIT-state abort is enabled by defining SCCB_ARB_TIMEOUT_EN.
module ov5640_sccb_arb
  import ov5640_pkg::*;
#(
  parameter int unsigned ADDR_W      = DefAddrW,
  parameter int unsigned DATA_W      = DefDataW,
  parameter int unsigned GAP_CYC     = 4,
  parameter int unsigned TIMEOUT_CYC = 2000
) (
  input  logic              sclk,
  input  logic              s_rst_n,
  input  logic              sccb_begin,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              resp_done,
  output logic              resp_id,
  output logic              resp_err,
  output logic              m_start,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_done,
  input  logic              m_nack,
  output logic              busy,
  output logic              err_sticky
);

  localparam logic [7:0] GapLoad = 8'(GAP_CYC - 1);

  sccb_arb_state_e   state_q, state_d;
  logic              rr_ptr_q;
  logic              owner_q;
  logic [ADDR_W-1:0] m_addr_q;
  logic [DATA_W-1:0] m_data_q;
  logic [7:0]        gap_cnt_q;
  logic              err_q;

  logic grant;
  logic accept;
  logic timeout_hit;
  logic resp_fire;
  logic resp_err_c;

  // With both valid, rr_ptr picks; otherwise whichever is valid wins.
  assign grant  = req1_valid & (~req0_valid | rr_ptr_q);
  assign accept = (state_q == StIdle) & sccb_begin & (grant ? req1_valid : req0_valid);

`ifdef SCCB_ARB_TIMEOUT_EN
  localparam int unsigned ToW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [ToW-1:0] ToLast = ToW'(TIMEOUT_CYC - 1);

  logic [ToW-1:0] to_cnt_q;

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      to_cnt_q <= '0;
    end else if (!sccb_begin || state_q == StIssue) begin
      to_cnt_q <= '0;
    end else if (state_q == StWait) begin
      to_cnt_q <= to_cnt_q + ToW'(1);
    end
  end

  assign timeout_hit = (state_q == StWait) & (to_cnt_q == ToLast);
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC;
  assign timeout_hit    = 1'b0;
`endif

  // A simultaneous m_done takes precedence over the timeout for the error flag.
  assign resp_fire  = (state_q == StWait) & sccb_begin & (m_done | timeout_hit);
  assign resp_err_c = m_done ? m_nack : 1'b1;

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!sccb_begin) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:  if (accept) state_d = StIssue;
        StIssue: state_d = StWait;
        StWait:  if (resp_fire) state_d = StGap;
        StGap:   if (gap_cnt_q == 8'd0) state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    m_start    = (state_q == StIssue);
    busy       = (state_q != StIdle);
    // Reset gating keeps ready low while s_rst_n is asserted even if sccb_begin is high.
    req0_ready = s_rst_n & (state_q == StIdle) & sccb_begin & (grant == REQ_CFG);
    req1_ready = s_rst_n & (state_q == StIdle) & sccb_begin & (grant == REQ_RT);
    resp_done  = resp_fire;
    resp_id    = resp_fire & owner_q;
    resp_err   = resp_fire & resp_err_c;
    m_addr     = m_addr_q;
    m_data     = m_data_q;
    err_sticky = err_q;
  end

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      rr_ptr_q  <= REQ_CFG;
      owner_q   <= REQ_CFG;
      m_addr_q  <= '0;
      m_data_q  <= '0;
      gap_cnt_q <= 8'd0;
      err_q     <= 1'b0;
    end else if (!sccb_begin) begin
      rr_ptr_q  <= REQ_CFG;
      gap_cnt_q <= 8'd0;
    end else begin
      if (accept) begin
        m_addr_q <= grant ? req1_addr : req0_addr;
        m_data_q <= grant ? req1_data : req0_data;
        owner_q  <= grant;
        rr_ptr_q <= ~grant;
      end
      if (resp_fire) begin
        gap_cnt_q <= GapLoad;
        if (resp_err_c) err_q <= 1'b1;
      end else if (state_q == StGap && gap_cnt_q != 8'd0) begin
        gap_cnt_q <= gap_cnt_q - 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_ov5640_sccb_arb.sv
// Self-checking bench for ov5640_sccb_arb: cycle-stamp reference model plus directed scenarios.
// Define SCCB_ARB_TIMEOUT_EN on both bench and RTL to exercise the WAIT abort.
module tb_ov5640_sccb_arb;

  localparam int unsigned GAP = 4;
  localparam int unsigned TO  = 2000;

  logic        sclk;
  logic        s_rst_n;
  logic        sccb_begin;
  logic        req0_valid, req1_valid;
  logic [15:0] req0_addr, req1_addr;
  logic [7:0]  req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic        resp_done, resp_id, resp_err;
  logic        m_start;
  logic [15:0] m_addr;
  logic [7:0]  m_data;
  logic        m_done, m_nack;
  logic        busy, err_sticky;

  ov5640_sccb_arb #(
    .ADDR_W     (16),
    .DATA_W     (8),
    .GAP_CYC    (GAP),
    .TIMEOUT_CYC(TO)
  ) dut (
    .sclk      (sclk),
    .s_rst_n   (s_rst_n),
    .sccb_begin(sccb_begin),
    .req0_valid(req0_valid),
    .req0_addr (req0_addr),
    .req0_data (req0_data),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid),
    .req1_addr (req1_addr),
    .req1_data (req1_data),
    .req1_ready(req1_ready),
    .resp_done (resp_done),
    .resp_id   (resp_id),
    .resp_err  (resp_err),
    .m_start   (m_start),
    .m_addr    (m_addr),
    .m_data    (m_data),
    .m_done    (m_done),
    .m_nack    (m_nack),
    .busy      (busy),
    .err_sticky(err_sticky)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  initial begin
    sclk = 1'b0;
    forever #5 sclk = ~sclk;
  end

  always @(posedge sclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Requester command queues ({addr, data}); valid is held while the queue is non-empty.
  logic [23:0] q0[$];
  logic [23:0] q1[$];

  initial begin
    bit hs0, hs1;
    req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
    forever begin
      @(negedge sclk);
      hs0 = req0_valid & req0_ready;
      hs1 = req1_valid & req1_ready;
      @(posedge sclk);
      #1;
      if (hs0) void'(q0.pop_front());
      if (hs1) void'(q1.pop_front());
      req0_valid = (q0.size() > 0);
      req1_valid = (q1.size() > 0);
      if (req0_valid) {req0_addr, req0_data} = q0[0];
      if (req1_valid) {req1_addr, req1_data} = q1[0];
    end
  end

  // Master model: answers mst_delay cycles after m_start unless silent.
  int mst_delay  = 10;
  bit mst_nack   = 1'b0;
  bit mst_silent = 1'b0;
  bit pend       = 1'b0;
  int pend_at    = 0;

  initial begin
    m_done = 1'b0;
    m_nack = 1'b0;
    forever begin
      @(negedge sclk);
      if (m_start && !mst_silent) begin
        pend    = 1'b1;
        pend_at = cyc + mst_delay;
      end
      @(posedge sclk);
      #1;
      m_done = 1'b0;
      m_nack = 1'b0;
      if (pend && cyc == pend_at) begin
        m_done = 1'b1;
        m_nack = mst_nack;
        pend   = 1'b0;
      end
    end
  end

  // Reference model: tracks the accepted command by cycle stamps, checks every cycle.
  bit          md_active, md_fin, md_rr, md_err, md_owner;
  int          md_acc, md_free;
  logic [15:0] md_addr;
  logic [7:0]  md_data;

  initial begin
    bit g, acc, waiting, to_hit, fire;
    bit e_r0, e_r1, e_ms, e_rd, e_id, e_err, e_busy, e_stk;
    md_active = 0; md_fin = 0; md_rr = 0; md_err = 0; md_owner = 0;
    md_acc = 0; md_free = 0; md_addr = '0; md_data = '0;
    forever begin
      @(negedge sclk);
      g = 0; acc = 0; fire = 0;
      if (!s_rst_n) begin
        md_active = 0; md_fin = 0; md_rr = 0; md_err = 0; md_owner = 0;
        md_addr = '0; md_data = '0;
        {e_r0, e_r1, e_ms, e_rd, e_id, e_err, e_busy, e_stk} = '0;
      end else begin
        g       = req1_valid & (!req0_valid | md_rr);
        e_r0    = !md_active & sccb_begin & !g;
        e_r1    = !md_active & sccb_begin & g;
        acc     = !md_active & sccb_begin & (g ? req1_valid : req0_valid);
        e_ms    = md_active && (cyc == md_acc + 1);
        waiting = md_active && !md_fin && (cyc >= md_acc + 2);
`ifdef SCCB_ARB_TIMEOUT_EN
        to_hit  = waiting && ((cyc - (md_acc + 2)) == int'(TO) - 1);
`else
        to_hit  = 0;
`endif
        fire    = waiting && sccb_begin && (m_done || to_hit);
        e_rd    = fire;
        e_id    = fire & md_owner;
        e_err   = fire & (m_done ? m_nack : 1'b1);
        e_busy  = md_active;
        e_stk   = md_err;
      end
      chk("cyc_ready", {30'd0, req1_ready, req0_ready}, {30'd0, e_r1, e_r0});
      chk("cyc_m_start", {31'd0, m_start}, {31'd0, e_ms});
      chk("cyc_resp", {29'd0, resp_done, resp_id, resp_err}, {29'd0, e_rd, e_id, e_err});
      chk("cyc_busy", {31'd0, busy}, {31'd0, e_busy});
      chk("cyc_err_sticky", {31'd0, err_sticky}, {31'd0, e_stk});
      chk("cyc_m_cmd", {8'd0, m_addr, m_data}, {8'd0, md_addr, md_data});
      if (s_rst_n) begin
        if (!sccb_begin) begin
          md_active = 0; md_fin = 0; md_rr = 0;
        end else if (acc) begin
          md_active = 1; md_fin = 0; md_acc = cyc; md_owner = g; md_rr = !g;
          md_addr   = g ? req1_addr : req0_addr;
          md_data   = g ? req1_data : req0_data;
        end else if (fire) begin
          md_fin  = 1;
          md_free = cyc + int'(GAP) + 1;
          if (e_err) md_err = 1;
        end else if (md_active && md_fin && (cyc + 1 == md_free)) begin
          md_active = 0;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge sclk);
      #1;
    end
  endtask

  // Wait at negedges for m_start (sel 0) or resp_done (sel 1), bounded by budget.
  task automatic wait_out(input int sel, input int budget, input string name,
                          output int at, output bit id, output bit err);
    bit hit;
    hit = 0; at = -1; id = 0; err = 0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge sclk);
      if ((sel == 0 && m_start) || (sel == 1 && resp_done)) begin
        hit = 1; at = cyc; id = resp_id; err = resp_err;
      end
    end
    if (!hit) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int s, d, prev_d, cnt;
    bit id, err;
    s_rst_n    = 1'b0;
    sccb_begin = 1'b0;
    tick(3);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_cmd", {8'd0, m_addr, m_data}, 32'd0);
    chk("rst_err_sticky", {31'd0, err_sticky}, 32'd0);
    s_rst_n = 1'b1;

    // 1: held off until sccb_begin, then 1-cycle issue latency
    q0.push_back({16'h3008, 8'h82});
    mst_delay = 3;
    tick(20);
    chk("t1_ready_held", {31'd0, req0_ready}, 32'd0);
    sccb_begin = 1'b1;
    #1;
    chk("t1_ready_same_cycle", {31'd0, req0_ready}, 32'd1);
    @(posedge sclk);
    #1;
    chk("t1_m_start", {31'd0, m_start}, 32'd1);
    chk("t1_m_addr", {16'd0, m_addr}, 32'h3008);
    chk("t1_m_data", {24'd0, m_data}, 32'h82);
    wait_out(1, 50, "t1_resp", d, id, err);
    chk("t1_resp_err", {31'd0, err}, 32'd0);
    tick(GAP + 2);

    // 2: both valid from reset, alternating grants and fixed done-to-start spacing
    s_rst_n = 1'b0;
    tick(2);
    q0.push_back({16'h3100, 8'h11}); q0.push_back({16'h3102, 8'h22});
    q1.push_back({16'h3500, 8'h33}); q1.push_back({16'h3502, 8'h44});
    tick(1);
    s_rst_n   = 1'b1;
    mst_delay = 10;
    prev_d    = 0;
    for (int k = 0; k < 4; k++) begin
      wait_out(0, 40, "t2_start", s, id, err);
      if (k > 0) chk("t2_done_to_start", s - prev_d, 32'd6);
      wait_out(1, 40, "t2_resp", d, id, err);
      chk("t2_resp_id", {31'd0, id}, k % 2);
      chk("t2_start_to_done", d - s, 32'd10);
      prev_d = d;
    end
    tick(GAP + 2);

    // 3: NACK on requester 1 sets the sticky flag, which survives a clean transaction
    mst_nack = 1'b1;
    q1.push_back({16'h3503, 8'h55});
    wait_out(0, 40, "t3_start", s, id, err);
    wait_out(1, 40, "t3_resp", d, id, err);
    mst_nack = 1'b0;
    chk("t3_resp_id", {31'd0, id}, 32'd1);
    chk("t3_resp_err", {31'd0, err}, 32'd1);
    tick(1);
    chk("t3_sticky", {31'd0, err_sticky}, 32'd1);
    tick(GAP + 2);
    q0.push_back({16'h3820, 8'h40});
    wait_out(0, 40, "t3b_start", s, id, err);
    wait_out(1, 40, "t3b_resp", d, id, err);
    chk("t3b_resp_err", {31'd0, err}, 32'd0);
    tick(1);
    chk("t3b_sticky_kept", {31'd0, err_sticky}, 32'd1);
    tick(GAP + 2);

    // 4: drop sccb_begin in WAIT; late m_done must not produce a response
    q0.push_back({16'h3212, 8'h01});
    wait_out(0, 40, "t4_start", s, id, err);
    tick(3);
    sccb_begin = 1'b0;
    tick(1);
    chk("t4_busy_dropped", {31'd0, busy}, 32'd0);
    q0.push_back({16'h3212, 8'h02});
    q1.push_back({16'h3a18, 8'h03});
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge sclk);
      if (resp_done) cnt++;
    end
    chk("t4_no_resp", cnt, 32'd0);
    @(posedge sclk);
    #1;
    sccb_begin = 1'b1;
    #1;
    chk("t4_grant0_ready0", {31'd0, req0_ready}, 32'd1);
    chk("t4_grant0_ready1", {31'd0, req1_ready}, 32'd0);
    wait_out(1, 60, "t4_drain_a", d, id, err);
    chk("t4_first_owner", {31'd0, id}, 32'd0);
    wait_out(1, 60, "t4_drain_b", d, id, err);
    tick(GAP + 2);

    // 5: silent master
    mst_silent = 1'b1;
    q0.push_back({16'h503d, 8'h80});
    wait_out(0, 40, "t5_start", s, id, err);
`ifdef SCCB_ARB_TIMEOUT_EN
    wait_out(1, TO + 50, "t5_resp", d, id, err);
    chk("t5_timeout_latency", d - s, TO);
    chk("t5_timeout_err", {31'd0, err}, 32'd1);
    tick(1);
    chk("t5_sticky", {31'd0, err_sticky}, 32'd1);
`else
    tick(300);
    chk("t5_busy_hung", {31'd0, busy}, 32'd1);
`endif
    mst_silent = 1'b0;

    // 6: asynchronous reset mid-GAP clears every output, including the sticky flag
    s_rst_n = 1'b0;
    tick(2);
    s_rst_n  = 1'b1;
    mst_nack = 1'b1;
    q0.push_back({16'h3008, 8'h02});
    wait_out(0, 40, "t6_start", s, id, err);
    wait_out(1, 40, "t6_resp", d, id, err);
    mst_nack = 1'b0;
    tick(1);
    chk("t6_in_gap_busy", {31'd0, busy}, 32'd1);
    chk("t6_in_gap_sticky", {31'd0, err_sticky}, 32'd1);
    #2;
    s_rst_n = 1'b0;
    #1;
    chk("t6_rst_flags", {24'd0, busy, err_sticky, m_start, resp_done, resp_id, resp_err,
                         req0_ready, req1_ready}, 32'd0);
    chk("t6_rst_cmd", {8'd0, m_addr, m_data}, 32'd0);
    tick(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
